axi4_slave_mem: RTL and testbench
=================================

# axi4_slave_mem

AXI4 slave-side responder: accepts write and read bursts on the AXI4 channels and services them from an internal word-organised memory array. It is the responder end of `axi4_if` (`slave_mp`) and serves as the memory DUT behind the UVM master agent. Write and read paths are independent, with one outstanding transaction per direction.

## Interface

- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 32, byte address width
- ID_WIDTH, 4, transaction ID width
- LEN_WIDTH, 8, burst length field width
- MEM_DEPTH, 1024, memory size in DATA_WIDTH words
- STRB_WIDTH, DATA_WIDTH/8, derived, not overridden
- aclk  input  1  single clock, all logic on the rising edge
- areset  input  1  synchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  input  ID/ADDR/LEN/3/2  AW payload
- awvalid / awready  input / output  1  AW handshake
- wdata/wstrb/wlast  input  DATA/STRB/1  W payload
- wvalid / wready  input / output  1  W handshake
- bid/bresp  output  ID/2  B payload
- bvalid / bready  output / input  1  B handshake
- arid/araddr/arlen/arsize/arburst  input  ID/ADDR/LEN/3/2  AR payload
- arvalid / arready  input / output  1  AR handshake
- rid/rdata/rresp/rlast  output  ID/DATA/2/1  R payload
- rvalid / rready  output / input  1  R handshake
- aw/ar lock, cache, prot  input  1/4/3  accepted and ignored; exclusive access gets OKAY, never EXOKAY

## Operation

- Word index = addr >> log2(STRB_WIDTH). A beat is in range when index < MEM_DEPTH.
- Beat address: FIXED keeps the start address. INCR adds 2^size. WRAP adds 2^size and wraps within an aligned window of (len+1)*2^size bytes.
- Request errors (SLVERR for the whole burst): burst=2'b11; WRAP with len not in {1,3,7,15}; size > log2(STRB_WIDTH).
- Write FSM: WS_ADDR → WS_DATA → WS_RESP → WS_ADDR.
  - WS_ADDR: awready=1. On handshake, latch id/addr/len/size/burst and clear the beat counter.
  - WS_DATA: wready=1. Each handshake writes the bytes with wstrb set to mem[index], only if in range and no request error. After beat len, go to WS_RESP.
  - WS_RESP: bvalid=1 with bid = latched awid. Hold until bready.
  - bresp priority: SLVERR (request error, or wlast != (beat==len) on any beat) > DECERR (any beat out of range) > OKAY.
- Read FSM: RS_ADDR → RS_DATA → RS_ADDR.
  - On AR handshake, load the rdata register with beat 0.
  - On each R handshake, load the next beat. Sustained throughput is 1 beat/cycle.
  - Per beat: rresp is SLVERR (request error), else DECERR (out of range), else OKAY. rdata is 0 for any non-OKAY beat.
  - rlast=1 on beat len. rid = latched arid.
- Same-cycle read load and write to the same word: the read returns the old data.
- Memory contents are not reset.

## Timing

- During areset and on the first cycle after it, all outputs are 0 (awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp).
- awready and arready first rise on the second cycle after areset deasserts.
- All outputs are registered.
- AW handshake at cycle N: wready=1 from N+1.
- Last W beat at cycle M: bvalid=1 at M+1.
- B handshake at cycle K: awready=1 at K+1.
- AR handshake at N: rvalid=1 at N+1.
- Last R handshake at K: rvalid=0 and arready=1 at K+1.
- rvalid, rdata, rresp, rlast and rid stay stable while rvalid && !rready.
- Reset mid-burst aborts both FSMs with no response. Memory writes already performed are kept.
- A simultaneous AW and AR handshake is legal. The two FSMs never block each other.

## Structure

- Package axi4_pkg:
  - burst_e: FIXED=0, INCR=1, WRAP=2
  - resp_e: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
  - state enums for both FSMs
  - function req_err(len, size, burst)
- Sub-module axi4_burst_addr_gen: combinational next-address from (addr, size, len, burst). Instanced once per FSM.

## Test plan

- Single INCR write: awaddr=0x10, len=0, wdata=0xDEADBEEF, wstrb=4'hF. Then read of 0x10. Expect bresp=OKAY, rdata=0xDEADBEEF, rlast=1.
- INCR len=3 write of 0x1..0x4 at 0x0, with rready toggling on the readback. Expect rdata 1,2,3,4, rlast only on the 4th beat, and data held stable while stalled.
- WRAP len=3 size=2 read at 0x18 (memory words 0x10–0x1C prefilled with A,B,C,D). Expect rdata order C,D,A,B.
- Partial strobe: write 0xFFFFFFFF over 0x00000000 with wstrb=4'b0101. Expect readback 0x00FF00FF.
- Errors:
  - awaddr = 4*MEM_DEPTH: expect bresp=DECERR and memory unchanged.
  - arburst=2'b11: expect each beat rresp=SLVERR with rdata=0.
  - wlast asserted early: expect bresp=SLVERR.
- Reset asserted mid-write (beat 2 of 4): expect bvalid never rises, all outputs 0, awready=1 on the second cycle after release, and the next transaction completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 types and helpers for the slave memory responder.
//   burst_e : AxBURST encodings (2'b11 is reserved and treated as a request error)
//   resp_e  : xRESP encodings
//   ws_e    : write-path FSM states
//   rs_e    : read-path FSM states
//   req_err : flags a burst request that must be answered with SLVERR on every beat
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        WS_ADDR = 2'd0,
        WS_DATA = 2'd1,
        WS_RESP = 2'd2
    } ws_e;

    typedef enum logic {
        RS_ADDR = 1'b0,
        RS_DATA = 1'b1
    } rs_e;

    // max_size is log2 of the data bus width in bytes; the package cannot know the
    // bus width, so the caller supplies it.
    function automatic logic req_err(input logic [15:0] len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst,
                                     input logic [2:0]  max_size);
        logic err;
        err = 1'b0;
        if (burst == 2'b11) begin
            err = 1'b1;
        end
        if ((burst == WRAP) &&
            !((len == 16'd1) || (len == 16'd3) || (len == 16'd7) || (len == 16'd15))) begin
            err = 1'b1;
        end
        if (size > max_size) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for an AXI4 burst.
// Ports:
//   i_addr      : address of the current beat
//   i_size      : AxSIZE (bytes per beat = 2^size)
//   i_len       : AxLEN (beats - 1), sets the WRAP window
//   i_burst     : AxBURST; reserved encoding behaves like FIXED
//   o_next_addr : address of the following beat
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_size,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);

    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_incr_addr;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;

    always_comb begin
        w_incr      = ADDR_WIDTH'(1) << i_size;
        w_incr_addr = i_addr + w_incr;
        // Window is (len+1)*2^size bytes and naturally aligned, so a mask selects
        // the offset inside it.
        w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
        case (i_burst)
            INCR:    o_next_addr = w_incr_addr;
            WRAP:    o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
            default: o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave responder backed by a word-organised memory array. Independent write and
// read FSMs, one outstanding transaction each; all outputs registered.
// Ports:
//   i_aclk, i_areset        : clock, synchronous active-high reset
//   i_aw* / o_awready       : write address channel (lock/cache/prot ignored)
//   i_w*  / o_wready        : write data channel
//   o_b*  / i_bready        : write response channel
//   i_ar* / o_arready       : read address channel (lock/cache/prot ignored)
//   o_r*  / i_rready        : read data channel
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    // AW
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [LEN_WIDTH-1:0]    i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awlock,
    input  logic [3:0]              i_awcache,
    input  logic [2:0]              i_awprot,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    // W
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    // B
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    // AR
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [LEN_WIDTH-1:0]    i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arlock,
    input  logic [3:0]              i_arcache,
    input  logic [2:0]              i_arprot,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    // R
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT  = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH   = $clog2(MEM_DEPTH);
    localparam logic [2:0]  MAX_SIZE    = 3'(BYTE_SHIFT);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(MEM_DEPTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> BYTE_SHIFT) < DEPTH_WORDS;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'(addr >> BYTE_SHIFT);
    endfunction

    logic w_unused_sideband;
    assign w_unused_sideband = ^{i_awlock, i_awcache, i_awprot, i_arlock, i_arcache, i_arprot};

    // Reset is stretched by one cycle so every output stays 0 on the first cycle
    // after release and the ready signals first rise on the second.
    logic r_rst_hold;
    logic w_rst;

    always_ff @(posedge i_aclk) begin
        r_rst_hold <= i_areset;
    end
    assign w_rst = i_areset | r_rst_hold;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ---------------- write path ----------------
    ws_e                   r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_aw_id;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [LEN_WIDTH-1:0]  r_aw_len;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;
    logic [LEN_WIDTH-1:0]  r_w_beat;
    logic                  r_w_reqerr;
    logic                  r_w_lasterr;
    logic                  r_w_decerr;

    logic [ADDR_WIDTH-1:0] w_aw_next;
    logic                  w_w_hs;
    logic                  w_w_last_beat;
    logic                  w_wr_inrange;
    logic                  w_mem_we;
    resp_e                 w_bresp;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_wr_addr_gen (
        .i_addr      (r_aw_addr),
        .i_size      (r_aw_size),
        .i_len       (r_aw_len),
        .i_burst     (r_aw_burst),
        .o_next_addr (w_aw_next)
    );

    always_comb begin
        w_w_hs        = r_wready & i_wvalid;
        w_w_last_beat = (r_w_beat == r_aw_len);
        w_wr_inrange  = in_range(r_aw_addr);
        // Gated by reset so a beat presented during reset never lands in memory.
        w_mem_we      = w_w_hs & ~w_rst & ~r_w_reqerr & w_wr_inrange;
        // Includes the current beat so the final beat's status reaches bresp.
        w_bresp = OKAY;
        if (r_w_reqerr || r_w_lasterr || (i_wlast != w_w_last_beat)) begin
            w_bresp = SLVERR;
        end else if (r_w_decerr || !w_wr_inrange) begin
            w_bresp = DECERR;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[word_idx(r_aw_addr)][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_rst) begin
            r_wstate    <= WS_ADDR;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= '0;
            r_aw_id     <= '0;
            r_aw_addr   <= '0;
            r_aw_len    <= '0;
            r_aw_size   <= '0;
            r_aw_burst  <= '0;
            r_w_beat    <= '0;
            r_w_reqerr  <= 1'b0;
            r_w_lasterr <= 1'b0;
            r_w_decerr  <= 1'b0;
        end else begin
            case (r_wstate)
                WS_ADDR: begin
                    if (r_awready && i_awvalid) begin
                        r_aw_id     <= i_awid;
                        r_aw_addr   <= i_awaddr;
                        r_aw_len    <= i_awlen;
                        r_aw_size   <= i_awsize;
                        r_aw_burst  <= i_awburst;
                        r_w_beat    <= '0;
                        r_w_reqerr  <= req_err(16'(i_awlen), i_awsize, i_awburst, MAX_SIZE);
                        r_w_lasterr <= 1'b0;
                        r_w_decerr  <= 1'b0;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_wstate    <= WS_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                WS_DATA: begin
                    if (w_w_hs) begin
                        if (i_wlast != w_w_last_beat) begin
                            r_w_lasterr <= 1'b1;
                        end
                        if (!w_wr_inrange) begin
                            r_w_decerr <= 1'b1;
                        end
                        r_aw_addr <= w_aw_next;
                        r_w_beat  <= r_w_beat + LEN_WIDTH'(1);
                        if (w_w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_aw_id;
                            r_bresp  <= w_bresp;
                            r_wstate <= WS_RESP;
                        end
                    end
                end
                WS_RESP: begin
                    if (i_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= WS_ADDR;
                    end
                end
                default: r_wstate <= WS_ADDR;
            endcase
        end
    end

    // ---------------- read path ----------------
    rs_e                   r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [LEN_WIDTH-1:0]  r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;
    logic                  r_ar_err;
    logic [LEN_WIDTH-1:0]  r_r_beat;

    logic [ADDR_WIDTH-1:0] w_ar_next;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_err;
    logic [DATA_WIDTH-1:0] w_rd_data;
    resp_e                 w_rd_resp;
    logic [LEN_WIDTH-1:0]  w_r_beat_next;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_rd_addr_gen (
        .i_addr      (r_ar_addr),
        .i_size      (r_ar_size),
        .i_len       (r_ar_len),
        .i_burst     (r_ar_burst),
        .o_next_addr (w_ar_next)
    );

    // The beat loaded into the rdata register: beat 0 straight from the AR payload on
    // the address handshake, otherwise the beat after the one being accepted.
    always_comb begin
        w_r_beat_next = r_r_beat + LEN_WIDTH'(1);
        if (r_rstate == RS_ADDR) begin
            w_rd_addr = i_araddr;
            w_rd_err  = req_err(16'(i_arlen), i_arsize, i_arburst, MAX_SIZE);
        end else begin
            w_rd_addr = w_ar_next;
            w_rd_err  = r_ar_err;
        end
        w_rd_data = '0;
        if (w_rd_err) begin
            w_rd_resp = SLVERR;
        end else if (!in_range(w_rd_addr)) begin
            w_rd_resp = DECERR;
        end else begin
            w_rd_resp = OKAY;
            w_rd_data = r_mem[word_idx(w_rd_addr)];
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_rst) begin
            r_rstate   <= RS_ADDR;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= '0;
            r_rlast    <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_ar_err   <= 1'b0;
            r_r_beat   <= '0;
        end else begin
            case (r_rstate)
                RS_ADDR: begin
                    if (r_arready && i_arvalid) begin
                        r_ar_addr  <= i_araddr;
                        r_ar_len   <= i_arlen;
                        r_ar_size  <= i_arsize;
                        r_ar_burst <= i_arburst;
                        r_ar_err   <= w_rd_err;
                        r_r_beat   <= '0;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rid      <= i_arid;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_resp;
                        r_rlast    <= (i_arlen == '0);
                        r_rstate   <= RS_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                RS_DATA: begin
                    if (i_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rdata   <= '0;
                            r_rresp   <= '0;
                            r_rid     <= '0;
                            r_arready <= 1'b1;
                            r_rstate  <= RS_ADDR;
                        end else begin
                            r_ar_addr <= w_rd_addr;
                            r_r_beat  <= w_r_beat_next;
                            r_rdata   <= w_rd_data;
                            r_rresp   <= w_rd_resp;
                            r_rlast   <= (w_r_beat_next == r_ar_len);
                        end
                    end
                end
                default: r_rstate <= RS_ADDR;
            endcase
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bid     = r_bid;
    assign o_bresp   = r_bresp;
    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_rlast   = r_rlast;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point.
module tb_axi4_slave_mem;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int tests = 0;
    int fails = 0;

    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [31:0] rexp [16];
    logic [1:0]  rrsp [16];

    always #5 aclk = ~aclk;

    axi4_slave_mem dut (
        .i_aclk    (aclk),
        .i_areset  (areset),
        .i_awid    (awid),
        .i_awaddr  (awaddr),
        .i_awlen   (awlen),
        .i_awsize  (awsize),
        .i_awburst (awburst),
        .i_awlock  (1'b0),
        .i_awcache (4'h0),
        .i_awprot  (3'h0),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wlast   (wlast),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bid     (bid),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .i_arid    (arid),
        .i_araddr  (araddr),
        .i_arlen   (arlen),
        .i_arsize  (arsize),
        .i_arburst (arburst),
        .i_arlock  (1'b0),
        .i_arcache (4'h0),
        .i_arprot  (3'h0),
        .i_arvalid (arvalid),
        .o_arready (arready),
        .o_rid     (rid),
        .o_rdata   (rdata),
        .o_rresp   (rresp),
        .o_rlast   (rlast),
        .o_rvalid  (rvalid),
        .i_rready  (rready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"},  32'(wready),  32'd0);
        check({tag, "_bvalid"},  32'(bvalid),  32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_rvalid"},  32'(rvalid),  32'd0);
        check({tag, "_out_bus"}, {bid, bresp, rid, rresp, rlast} | rdata, 32'd0);
    endtask

    // Write burst from wdat/wstb; early_last drives wlast=1 on every beat.
    task automatic write_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] id,
                               input bit early_last, input logic [1:0] exp_resp);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        check({tag, "_aw_wait"}, 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        check({tag, "_wready_after_aw"}, 32'(wready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wdat[i]; wstrb = wstb[i]; wvalid = 1'b1;
            wlast = early_last ? 1'b1 : (i == int'(len));
            n = 0;
            while (!wready && n < 20) begin tick(); n++; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "_wready_low"}, 32'(wready), 32'd0);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(bid), 32'(id));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
        check({tag, "_awready_back"}, 32'(awready), 32'd1);
    endtask

    // Read burst checked against rexp/rrsp; stall holds rready low for one cycle on
    // even beats and checks the beat is held.
    task automatic read_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] id, input bit stall);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        check({tag, "_ar_wait"}, 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            check($sformatf("%s_rdata%0d", tag, i), rdata, rexp[i]);
            check($sformatf("%s_rresp%0d", tag, i), 32'(rresp), 32'(rrsp[i]));
            check($sformatf("%s_rlast%0d", tag, i), 32'(rlast), 32'(i == int'(len)));
            check($sformatf("%s_rid%0d", tag, i), 32'(rid), 32'(id));
            if (stall && (i % 2 == 0)) begin
                rready = 1'b0;
                tick();
                check($sformatf("%s_hold_valid%0d", tag, i), 32'(rvalid), 32'd1);
                check($sformatf("%s_hold_data%0d", tag, i), rdata, rexp[i]);
                check($sformatf("%s_hold_last%0d", tag, i), 32'(rlast), 32'(i == int'(len)));
            end
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        check({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
        check({tag, "_arready_back"}, 32'(arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset behaviour
        tick(); tick(); tick();
        check_idle_zero("in_reset");
        areset = 1'b0;
        tick();
        check_idle_zero("post_reset_c1");
        tick();
        check("post_reset_c2_awready", 32'(awready), 32'd1);
        check("post_reset_c2_arready", 32'(arready), 32'd1);

        // Single INCR write and readback
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        write_burst("single_wr", 32'h10, 8'd0, 2'b01, 4'h3, 1'b0, 2'd0);
        rexp[0] = 32'hDEADBEEF; rrsp[0] = 2'd0;
        read_burst("single_rd", 32'h10, 8'd0, 2'b01, 4'h5, 1'b0);

        // INCR len=3 and a stalled readback
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i + 1); wstb[i] = 4'hF; rexp[i] = 32'(i + 1); rrsp[i] = 2'd0;
        end
        write_burst("incr4_wr", 32'h0, 8'd3, 2'b01, 4'h1, 1'b0, 2'd0);
        read_burst("incr4_rd", 32'h0, 8'd3, 2'b01, 4'h2, 1'b1);

        // WRAP read starting mid-window
        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
        write_burst("wrap_fill", 32'h10, 8'd3, 2'b01, 4'h4, 1'b0, 2'd0);
        rexp[0] = 32'hC; rexp[1] = 32'hD; rexp[2] = 32'hA; rexp[3] = 32'hB;
        read_burst("wrap_rd", 32'h18, 8'd3, 2'b10, 4'h6, 1'b0);

        // Partial strobe
        wdat[0] = 32'h0000_0000; wstb[0] = 4'hF;
        write_burst("strb_clear", 32'h40, 8'd0, 2'b01, 4'h7, 1'b0, 2'd0);
        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'b0101;
        write_burst("strb_wr", 32'h40, 8'd0, 2'b01, 4'h7, 1'b0, 2'd0);
        rexp[0] = 32'h00FF_00FF;
        read_burst("strb_rd", 32'h40, 8'd0, 2'b01, 4'h8, 1'b0);

        // Out-of-range write: word 0 (which the index would alias to) must survive
        wdat[0] = 32'h1234_5678; wstb[0] = 4'hF;
        write_burst("decerr_wr", 32'h1000, 8'd0, 2'b01, 4'h9, 1'b0, 2'd3);
        rexp[0] = 32'h1;
        read_burst("decerr_keep", 32'h0, 8'd0, 2'b01, 4'h9, 1'b0);
        rexp[0] = 32'h0; rrsp[0] = 2'd3;
        read_burst("decerr_rd", 32'h1000, 8'd0, 2'b01, 4'hA, 1'b0);

        // Reserved burst type on read
        rexp[0] = 32'h0; rexp[1] = 32'h0; rrsp[0] = 2'd2; rrsp[1] = 2'd2;
        read_burst("rsvd_burst_rd", 32'h0, 8'd1, 2'b11, 4'hB, 1'b0);

        // Early wlast
        wdat[0] = 32'h5; wdat[1] = 32'h6; wstb[0] = 4'hF; wstb[1] = 4'hF;
        write_burst("early_wlast", 32'h80, 8'd1, 2'b01, 4'hC, 1'b1, 2'd2);

        // Reset in the middle of a 4-beat write
        awid = 4'h1; awaddr = 32'h100; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("rst_mid_wready", 32'(wready), 32'd1);
        wstrb = 4'hF; wvalid = 1'b1; wlast = 1'b0;
        wdata = 32'h11; tick();
        wdata = 32'h22; tick();
        wdata = 32'h33; areset = 1'b1;
        tick();
        check_idle_zero("rst_mid_c0");
        tick();
        check("rst_mid_c1_bvalid", 32'(bvalid), 32'd0);
        areset = 1'b0; wvalid = 1'b0;
        tick();
        check_idle_zero("rst_mid_rel1");
        tick();
        check("rst_mid_rel2_awready", 32'(awready), 32'd1);
        check("rst_mid_rel2_bvalid", 32'(bvalid), 32'd0);
        rrsp[0] = 2'd0; rexp[0] = 32'h11;
        read_burst("rst_kept0", 32'h100, 8'd0, 2'b01, 4'h2, 1'b0);
        rexp[0] = 32'h22;
        read_burst("rst_kept1", 32'h104, 8'd0, 2'b01, 4'h2, 1'b0);
        wdat[0] = 32'h55; wstb[0] = 4'hF;
        write_burst("rst_after_wr", 32'h108, 8'd0, 2'b01, 4'h3, 1'b0, 2'd0);
        rexp[0] = 32'h55;
        read_burst("rst_after_rd", 32'h108, 8'd0, 2'b01, 4'h3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
